// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide unit with its own sequencer.
// Multiplies with a shift-add loop and divides with a restoring loop, one
// bit per cycle on operand magnitudes. A single FIX cycle then applies the
// sign correction and selects the result word. Divide-by-zero and signed
// overflow skip the loop and finish one cycle after the op is accepted.
module mdu_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      mduop,
   input  logic [XLEN-1:0] opr_a,
   input  logic [XLEN-1:0] opr_b,
   input  logic            kill,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] res
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   // Two's-complement negation, wrapping modulo 2^XLEN.
   function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
      return ~v + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   // Two's-complement negation of a double-width product.
   function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
      return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
   endfunction

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic [XLEN-1:0]     opa_q, opa_d;
   logic [XLEN-1:0]     opb_q, opb_d;
   logic                neg_a_q, neg_a_d;
   logic                neg_b_q, neg_b_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN:0]       rem_q, rem_d;
   logic [XLEN-1:0]     res_q, res_d;

   // Operand decode for the op presented in IDLE.
   logic                in_is_div, in_a_signed, in_b_signed;
   logic                in_neg_a, in_neg_b;
   logic [XLEN-1:0]     in_abs_a, in_abs_b;
   logic                in_div_zero, in_ovf, in_fast;
   logic [XLEN-1:0]     fast_res;

   assign in_is_div   = mduop[2];
   assign in_a_signed = (mduop == OP_MULH) || (mduop == OP_MULHSU) ||
                        (mduop == OP_DIV)  || (mduop == OP_REM);
   assign in_b_signed = (mduop == OP_MULH) || (mduop == OP_DIV) || (mduop == OP_REM);
   assign in_neg_a    = in_a_signed & opr_a[XLEN-1];
   assign in_neg_b    = in_b_signed & opr_b[XLEN-1];
   assign in_abs_a    = in_neg_a ? neg_w(opr_a) : opr_a;
   assign in_abs_b    = in_neg_b ? neg_w(opr_b) : opr_b;
   assign in_div_zero = in_is_div && (opr_b == {XLEN{1'b0}});
   // Only the signed forms (DIV, REM) have funct3 bit 0 clear.
   assign in_ovf      = in_is_div && !mduop[0] && (opr_a == INT_MIN) &&
                        (opr_b == {XLEN{1'b1}});
   assign in_fast     = in_div_zero || in_ovf;
   // funct3 bit 1 selects remainder over quotient for divides.
   assign fast_res    = in_div_zero ? (mduop[1] ? opr_a : {XLEN{1'b1}})
                                    : (mduop[1] ? {XLEN{1'b0}} : INT_MIN);

   // One multiply step: conditionally add the multiplicand into the high word.
   logic [XLEN:0]       mul_sum;
   assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});

   // One divide step: shift in the next dividend bit and trial-subtract.
   logic [XLEN+1:0]     div_shift, div_diff;
   logic                div_fits;
   assign div_shift = {rem_q, acc_q[XLEN-1]};
   assign div_diff  = div_shift - {2'b00, opb_q};
   assign div_fits  = !div_diff[XLEN+1];

   // Sign correction applied in FIX.
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     quot_fix, rem_fix, fix_res;
   assign prod_fix = (neg_a_q ^ neg_b_q) ? neg_dw(acc_q) : acc_q;
   assign quot_fix = (neg_a_q ^ neg_b_q) ? neg_w(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
   assign rem_fix  = neg_a_q ? neg_w(rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];

   // Select the architectural result word for the latched op.
   always_comb begin
      fix_res = prod_fix[XLEN-1:0];
      case (op_q)
         OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fix_res = quot_fix;
         OP_REM, OP_REMU:              fix_res = rem_fix;
         default:                      fix_res = prod_fix[XLEN-1:0];
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; kill overrides every transition.
   always_comb begin
      state_d = state_q;
      if (kill) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (in_fast) begin
                     state_d = S_DONE;
                  end else if (in_is_div) begin
                     state_d = S_DIV;
                  end else begin
                     state_d = S_MUL;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_MUL: begin
               if (cnt_q == CNT_LAST) begin
                  state_d = S_FIX;
               end else begin
                  state_d = S_MUL;
               end
            end
            S_DIV: begin
               if (cnt_q == CNT_LAST) begin
                  state_d = S_FIX;
               end else begin
                  state_d = S_DIV;
               end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM outputs: pipeline hold request and result-valid pulse.
   always_comb begin
      stall = 1'b0;
      done  = 1'b0;
      if (rst) begin
         stall = 1'b0;
      end else begin
         stall = ((state_q == S_IDLE) && start && !kill) ||
                 (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
      end
      if (state_q == S_DONE) begin
         done = 1'b1;
      end else begin
         done = 1'b0;
      end
   end

   // Datapath next-state: operand capture, iteration steps and result write.
   always_comb begin
      cnt_d   = cnt_q;
      op_d    = op_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      res_d   = res_q;
      if (kill) begin
         cnt_d = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_d    = mduop;
                  opa_d   = in_abs_a;
                  opb_d   = in_abs_b;
                  neg_a_d = in_neg_a;
                  neg_b_d = in_neg_b;
                  cnt_d   = {CNT_W{1'b0}};
                  rem_d   = {(XLEN+1){1'b0}};
                  // Low word holds the multiplier or the dividend being shifted out.
                  acc_d   = {{XLEN{1'b0}}, (in_is_div ? in_abs_a : in_abs_b)};
                  if (in_fast) begin
                     res_d = fast_res;
                  end else begin
                     res_d = res_q;
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            S_MUL: begin
               acc_d = {mul_sum, acc_q[XLEN-1:1]};
               cnt_d = cnt_q + CNT_ONE;
            end
            S_DIV: begin
               if (div_fits) begin
                  rem_d = div_diff[XLEN:0];
                  acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_d = div_shift[XLEN:0];
                  acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
               end
               cnt_d = cnt_q + CNT_ONE;
            end
            S_FIX: begin
               res_d = fix_res;
               cnt_d = {CNT_W{1'b0}};
            end
            S_DONE: begin
               cnt_d = {CNT_W{1'b0}};
            end
            default: begin
               cnt_d = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= {CNT_W{1'b0}};
         op_q    <= 3'd0;
         opa_q   <= {XLEN{1'b0}};
         opb_q   <= {XLEN{1'b0}};
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         acc_q   <= {(2*XLEN){1'b0}};
         rem_q   <= {(XLEN+1){1'b0}};
         res_q   <= {XLEN{1'b0}};
      end else begin
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         res_q   <= res_d;
      end
   end

   assign res = res_q;

endmodule
